output_queue: RTL and testbench



---
 rtl/output_queue.sv | 82 ++++++++
 tb/tb_output_queue.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/output_queue.sv
// FIFO holding result words until the host acknowledges them; reports empty/full/overflow.
// Optional macro OUTPUT_QUEUE_OVERWRITE_EN: a push into a full queue evicts the oldest entry.
module output_queue #(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 4,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_in_pulse,
  input  logic              read_ack,
  input  logic              flush,
  output logic [DATA_W-1:0] data_out,
  output logic              ready,
  output logic              full,
  output logic [CNT_W-1:0]  count,
  output logic              overflow
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [0:DEPTH-1];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic              pop, push_blocked, do_write, adv_rd;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign ready    = (count != '0);
  assign full     = (count == CNT_W'(DEPTH));
  assign data_out = ready ? mem[rd_ptr] : '0;

  always_comb begin
    pop          = read_ack && ready;
    push_blocked = data_in_pulse && full && !pop;
`ifdef OUTPUT_QUEUE_OVERWRITE_EN
    // Blocked push evicts the head: both pointers advance together.
    do_write     = data_in_pulse;
    adv_rd       = pop || push_blocked;
`else
    do_write     = data_in_pulse && !push_blocked;
    adv_rd       = pop;
`endif
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      if (data_in_pulse) mem[0] <= data_in;
    end else if (do_write) begin
      mem[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (flush) begin
      // A push coinciding with flush survives as the sole entry in slot 0.
      rd_ptr   <= '0;
      overflow <= 1'b0;
      if (data_in_pulse) begin
        wr_ptr <= PTR_W'(1);
        count  <= CNT_W'(1);
      end else begin
        wr_ptr <= '0;
        count  <= '0;
      end
    end else begin
      if (do_write) wr_ptr <= ptr_next(wr_ptr);
      if (adv_rd)   rd_ptr <= ptr_next(rd_ptr);
      if (do_write && !adv_rd)      count <= count + 1'b1;
      else if (adv_rd && !do_write) count <= count - 1'b1;
      if (push_blocked) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_output_queue.sv
// Scoreboard bench for output_queue: queue-based reference model, directed then random stimulus.
module tb_output_queue;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              nrst;
  logic [DATA_W-1:0] data_in;
  logic              data_in_pulse, read_ack, flush;
  logic [DATA_W-1:0] data_out;
  logic              ready, full, overflow;
  logic [CNT_W-1:0]  count;

  output_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .nrst(nrst), .data_in(data_in), .data_in_pulse(data_in_pulse),
    .read_ack(read_ack), .flush(flush), .data_out(data_out), .ready(ready),
    .full(full), .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] d;
    logic              rdy;
    logic              fl;
    logic              ov;
    int                cnt;
  } exp_t;

  exp_t              exp_q[$];
  logic [DATA_W-1:0] mq[$];
  logic              mov;
  int                vectors = 0;
  int                miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic exp_t model_outputs();
    exp_t e;
    e.cnt = mq.size();
    e.d   = (mq.size() != 0) ? mq[0] : '0;
    e.rdy = (mq.size() != 0);
    e.fl  = (mq.size() == DEPTH);
    e.ov  = mov;
    return e;
  endfunction

  // Monitor: compares DUT outputs against each expected response, half a cycle after the edge.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("data_out", 32'(data_out), 32'(e.d));
      check("ready",    32'(ready),    32'(e.rdy));
      check("full",     32'(full),     32'(e.fl));
      check("count",    32'(count),    32'(e.cnt));
      check("overflow", 32'(overflow), 32'(e.ov));
    end
  end

  // One clock of stimulus; the model applies the queue rules, then the expected state is queued.
  task automatic cycle(input logic p, input logic [DATA_W-1:0] d, input logic a, input logic f);
    data_in_pulse = p; data_in = d; read_ack = a; flush = f;
    if (f) begin
      mq.delete();
      mov = 1'b0;
      if (p) mq.push_back(d);
    end else begin
      bit popped;
      popped = a && (mq.size() != 0);
      if (popped) void'(mq.pop_front());
      if (p) begin
        if (mq.size() < DEPTH) mq.push_back(d);
        else begin
          mov = 1'b1;
`ifdef OUTPUT_QUEUE_OVERWRITE_EN
          void'(mq.pop_front());
          mq.push_back(d);
`endif
        end
      end
    end
    @(posedge clk);
    #1;
    data_in_pulse = 1'b0; read_ack = 1'b0; flush = 1'b0;
    exp_q.push_back(model_outputs());
  endtask

  task automatic push(input logic [DATA_W-1:0] d); cycle(1'b1, d, 1'b0, 1'b0); endtask
  task automatic ack();                            cycle(1'b0, '0, 1'b1, 1'b0); endtask

  initial begin
    nrst = 1'b0; data_in = '0; data_in_pulse = 1'b0; read_ack = 1'b0; flush = 1'b0;
    mov = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    nrst = 1'b1;
    exp_q.push_back(model_outputs());

    // Idle acks on empty queue
    ack(); ack();
    cycle(1'b0, '0, 1'b0, 1'b0);

    // Basic order
    push(8'hA1); push(8'hB2); push(8'hC3);
    ack(); ack(); ack();

    // Fill, overflow, drain; overflow remains sticky
    for (int unsigned i = 0; i < 4; i++) push(8'(8'h10 + i));
    push(8'h14);
    for (int unsigned i = 0; i < 4; i++) ack();

    // Overflow set: push two, then flush with a concurrent push
    push(8'h20); push(8'h21);
    cycle(1'b1, 8'h99, 1'b1, 1'b1);
    ack();

    // Full with simultaneous push/pop, then drain through the wrap
    for (int unsigned i = 0; i < 4; i++) push(8'(8'h30 + i));
    cycle(1'b1, 8'h55, 1'b1, 1'b0);
    for (int unsigned i = 0; i < 4; i++) ack();

    // Empty with simultaneous push/pop
    cycle(1'b1, 8'h7E, 1'b1, 1'b0);
    push(8'h61); push(8'h62);

    // Asynchronous reset mid-cycle, after the monitor has consumed pending expectations
    @(negedge clk);
    #1;
    nrst = 1'b0;
    #1;
    check("rst_data_out", 32'(data_out), 32'h0);
    check("rst_ready",    32'(ready),    32'h0);
    check("rst_full",     32'(full),     32'h0);
    check("rst_count",    32'(count),    32'h0);
    check("rst_overflow", 32'(overflow), 32'h0);
    mq.delete();
    mov = 1'b0;
    @(posedge clk);
    #1;
    nrst = 1'b1;
    exp_q.push_back(model_outputs());

    // Randomized traffic
    for (int unsigned i = 0; i < 600; i++) begin
      logic p, a, f;
      p = ($urandom_range(99) < 55);
      a = ($urandom_range(99) < 40);
      f = ($urandom_range(99) < 3);
      cycle(p, 8'($urandom), a, f);
    end

    cycle(1'b0, '0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
